sgdmac_read: RTL

Read engine of the scatter-gather DMA controller: it reads the source buffer into the shared data FIFO. Each accepted command of {source address, byte count} becomes a sequence of AXI3 INCR read bursts of up to 16 x 4-byte beats. Returned data is written word-by-word into the data buffer, which the write engine then drains. It sits between the descriptor unit and the AXI read channels (AR/R) of the DMA master port.

---
 rtl/sgdmac_read.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sgdmac_read.sv
// Scatter-gather DMA read engine: splits {src_addr, byte_count} into AXI3 INCR bursts of up to 16 words and streams R data into the data FIFO.
// Latency: AR one cycle after accept; one beat per cycle; backpressure via fifo_full_i drops rready_o combinationally. Optional SGDMAC_READ_ERR_EN adds sticky err_o.
module sgdmac_read #(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic        start_i,
    input  logic [47:0] cmd_i,
    output logic        done_o,
    input  logic        fifo_full_i,
    output logic        fifo_wren_o,
    output logic [31:0] fifo_wdata_o
`ifdef SGDMAC_READ_ERR_EN
    ,
    output logic        err_o
`endif
);

    typedef enum logic [1:0] {IDLE, ADDR_REQ, DATA_RX} state_t;

    state_t      state_q;
    logic [15:0] remain_q;
    logic [3:0]  beat_cnt_q;
    logic [31:0] araddr_q;
    logic [3:0]  arlen_q;

    logic [15:0] cmd_remain_d;
    logic [15:0] remain_d;
    logic        accept;
    logic        ar_hs;
    logic        r_hs;

    // Full 64-byte bursts while possible, otherwise exactly the words left.
    function automatic logic [3:0] burst_len(input logic [15:0] r);
        return (r >= 16'd64) ? 4'hF : (r[5:2] - 4'd1);
    endfunction

    assign cmd_remain_d = {cmd_i[15:2], 2'b00};
    assign remain_d     = remain_q - {9'd0, ({1'b0, arlen_q} + 5'd1), 2'b00};
    assign accept       = (state_q == IDLE) && start_i && (cmd_i[15:2] != 14'd0);
    assign ar_hs        = (state_q == ADDR_REQ) && arready_i;
    assign r_hs         = (state_q == DATA_RX) && rvalid_i && !fifo_full_i;

    assign arid_o       = ID;
    assign araddr_o     = araddr_q;
    assign arlen_o      = arlen_q;
    assign arsize_o     = 3'b010;
    assign arburst_o    = 2'b01;
    assign arvalid_o    = (state_q == ADDR_REQ);
    assign done_o       = (state_q == IDLE);
    assign rready_o     = (state_q == DATA_RX) && !fifo_full_i;
    assign fifo_wren_o  = r_hs;
    assign fifo_wdata_o = rdata_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            remain_q   <= 16'd0;
            beat_cnt_q <= 4'd0;
            araddr_q   <= 32'd0;
            arlen_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        remain_q <= cmd_remain_d;
                        araddr_q <= cmd_i[47:16];
                        arlen_q  <= burst_len(cmd_remain_d);
                        state_q  <= ADDR_REQ;
                    end
                end
                ADDR_REQ: begin
                    if (ar_hs) begin
                        beat_cnt_q <= arlen_q;
                        remain_q   <= remain_d;
                        araddr_q   <= araddr_q + 32'd64;
                        state_q    <= DATA_RX;
                    end
                end
                DATA_RX: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q - 4'd1;
                        if (beat_cnt_q == 4'd0) begin
                            if (remain_q == 16'd0) begin
                                state_q <= IDLE;
                            end else begin
                                arlen_q <= burst_len(remain_q);
                                state_q <= ADDR_REQ;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SGDMAC_READ_ERR_EN
    logic err_q;
    logic err_hit;

    assign err_hit = r_hs && (rresp_i[1] || (rid_i != ID) || (rlast_i != (beat_cnt_q == 4'd0)));
    assign err_o   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end else if (accept) begin
            err_q <= 1'b0;
        end
    end

    logic unused_in;
    assign unused_in = ^{cmd_i[1:0], rresp_i[0]};
`else
    // The data path trusts its own beat count; R sideband is not inspected.
    logic unused_in;
    assign unused_in = ^{cmd_i[1:0], rid_i, rresp_i, rlast_i};
`endif

endmodule
